// File: rtl/drac_pkg.sv
// Shared fetch-side types for the instruction cache line responder.
package drac_pkg;

    localparam int ICACHE_LINE_BYTES = 16;
    localparam int ICACHE_WORDS      = ICACHE_LINE_BYTES / 4;

    typedef logic [127:0] icache_line_t;
    typedef logic [35:0]  ic_tag_t;

    typedef struct packed {
        logic        valid;
        logic [39:0] vaddr;
        logic        invalidate_icache;
        logic        invalidate_buffer;
    } req_cpu_icache_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] data;
        logic        instr_access_fault;
        logic        instr_page_fault;
    } resp_icache_cpu_t;

    typedef enum logic [1:0] {
        IC_IDLE        = 2'd0,
        IC_REFILL_REQ  = 2'd1,
        IC_REFILL_WAIT = 2'd2,
        IC_RESPOND     = 2'd3
    } icache_resp_state_t;

    // Select one 32-bit instruction word out of a cache line.
    function automatic logic [31:0] line_word(input icache_line_t line, input logic [1:0] idx);
        logic [31:0] word;
        case (idx)
            2'd0:    word = line[31:0];
            2'd1:    word = line[63:32];
            2'd2:    word = line[95:64];
            2'd3:    word = line[127:96];
            default: word = 32'd0;
        endcase
        return word;
    endfunction

endpackage

// File: rtl/icache_fetch_fault_chk.sv
// Combinational fetch fault classification: canonical-address and memory-range checks.
module icache_fetch_fault_chk
    import drac_pkg::*;
#(
    parameter logic [39:0] MEM_BASE = 40'h0080000000,
    parameter logic [39:0] MEM_SIZE = 40'h0010000000,
    parameter int          VA_BITS  = 39
) (
    input  logic [39:0] i_vaddr,
    output logic        o_page_fault,
    output logic        o_access_fault
);

    localparam int HI_W = 40 - (VA_BITS - 1);

    logic [HI_W-1:0] w_hi_bits;
    logic [40:0]     w_addr;
    logic [40:0]     w_lo_bound;
    logic [40:0]     w_hi_bound;

    // Upper bits must all match the sign bit; range bound is computed in 41 bits so it never wraps.
    always_comb begin
        w_hi_bits      = i_vaddr[39:VA_BITS-1];
        w_addr         = {1'b0, i_vaddr};
        w_lo_bound     = {1'b0, MEM_BASE};
        w_hi_bound     = {1'b0, MEM_BASE} + {1'b0, MEM_SIZE};
        o_page_fault   = (w_hi_bits != {HI_W{1'b0}}) && (w_hi_bits != {HI_W{1'b1}});
        o_access_fault = (w_addr < w_lo_bound) || (w_addr >= w_hi_bound);
    end

endmodule

// File: rtl/icache_line_responder.sv
// Single-line instruction buffer: answers fetch requests, refilling the line from L2 on a miss.
module icache_line_responder
    import drac_pkg::*;
#(
    parameter logic [39:0] MEM_BASE = 40'h0080000000,
    parameter logic [39:0] MEM_SIZE = 40'h0010000000,
    parameter int          VA_BITS  = 39
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  req_cpu_icache_t  req_cpu_icache_i,
    output resp_icache_cpu_t resp_icache_cpu_o,
    output logic             retry_fetch_o,
    output logic             l2_req_valid_o,
    output logic [39:0]      l2_req_addr_o,
    input  logic             l2_req_ready_i,
    input  logic             l2_resp_valid_i,
    input  logic [127:0]     l2_resp_data_i,
    input  logic             l2_resp_error_i
);

    icache_resp_state_t r_state;
    icache_line_t       r_line;
    ic_tag_t            r_tag;
    logic               r_line_valid;
    logic               r_discard;
    logic [39:0]        r_vaddr;
    logic               r_err;
    resp_icache_cpu_t   r_resp;
    logic               r_l2_req_valid;
    logic [39:0]        r_l2_req_addr;

    icache_resp_state_t w_state_n;
    icache_line_t       w_line_n;
    ic_tag_t            w_tag_n;
    logic               w_line_valid_n;
    logic               w_discard_n;
    logic [39:0]        w_vaddr_n;
    logic               w_err_n;
    resp_icache_cpu_t   w_resp_n;
    logic               w_l2_req_valid_n;
    logic [39:0]        w_l2_req_addr_n;

    logic               w_inv;
    logic               w_hit;
    logic               w_page_fault;
    logic               w_access_fault;

    icache_fetch_fault_chk #(
        .MEM_BASE (MEM_BASE),
        .MEM_SIZE (MEM_SIZE),
        .VA_BITS  (VA_BITS)
    ) u_fault_chk (
        .i_vaddr        (req_cpu_icache_i.vaddr),
        .o_page_fault   (w_page_fault),
        .o_access_fault (w_access_fault)
    );

    // A request is only taken in IDLE; anything offered elsewhere is dropped and must be replayed.
    assign retry_fetch_o     = !rst_i && req_cpu_icache_i.valid && (r_state != IC_IDLE);
    assign resp_icache_cpu_o = r_resp;
    assign l2_req_valid_o    = r_l2_req_valid;
    assign l2_req_addr_o     = r_l2_req_addr;

    // Next-state and next-output logic; an invalidate in the same cycle forces a miss.
    always_comb begin
        w_inv            = req_cpu_icache_i.invalidate_icache | req_cpu_icache_i.invalidate_buffer;
        w_hit            = r_line_valid && !w_inv && (r_tag == req_cpu_icache_i.vaddr[39:4]);
        w_state_n        = r_state;
        w_line_n         = r_line;
        w_tag_n          = r_tag;
        w_line_valid_n   = r_line_valid & ~w_inv;
        w_discard_n      = r_discard;
        w_vaddr_n        = r_vaddr;
        w_err_n          = r_err;
        w_resp_n         = '0;
        w_l2_req_valid_n = r_l2_req_valid;
        w_l2_req_addr_n  = r_l2_req_addr;

        case (r_state)
            IC_IDLE: begin
                if (req_cpu_icache_i.valid) begin
                    if (w_page_fault) begin
                        w_resp_n.valid            = 1'b1;
                        w_resp_n.instr_page_fault = 1'b1;
                    end else if (w_access_fault) begin
                        w_resp_n.valid              = 1'b1;
                        w_resp_n.instr_access_fault = 1'b1;
                    end else if (w_hit) begin
                        w_resp_n.valid = 1'b1;
                        w_resp_n.data  = line_word(r_line, req_cpu_icache_i.vaddr[3:2]);
                    end else begin
                        w_state_n        = IC_REFILL_REQ;
                        w_vaddr_n        = req_cpu_icache_i.vaddr;
                        w_l2_req_valid_n = 1'b1;
                        w_l2_req_addr_n  = {req_cpu_icache_i.vaddr[39:4], 4'b0000};
                        w_discard_n      = 1'b0;
                        w_err_n          = 1'b0;
                    end
                end else begin
                    w_state_n = IC_IDLE;
                end
            end
            IC_REFILL_REQ: begin
                if (w_inv) begin
                    w_discard_n = 1'b1;
                end else begin
                    w_discard_n = r_discard;
                end
                if (l2_req_ready_i) begin
                    w_state_n        = IC_REFILL_WAIT;
                    w_l2_req_valid_n = 1'b0;
                end else begin
                    w_state_n = IC_REFILL_REQ;
                end
            end
            IC_REFILL_WAIT: begin
                if (w_inv) begin
                    w_discard_n = 1'b1;
                end else begin
                    w_discard_n = r_discard;
                end
                if (l2_resp_valid_i) begin
                    // Data is always captured for the pending response; the line only becomes valid when clean.
                    w_line_n       = l2_resp_data_i;
                    w_tag_n        = r_vaddr[39:4];
                    w_err_n        = l2_resp_error_i;
                    w_line_valid_n = !l2_resp_error_i && !r_discard && !w_inv;
                    w_state_n      = IC_RESPOND;
                end else begin
                    w_state_n = IC_REFILL_WAIT;
                end
            end
            IC_RESPOND: begin
                w_resp_n.valid = 1'b1;
                if (r_err) begin
                    w_resp_n.instr_access_fault = 1'b1;
                end else begin
                    w_resp_n.data = line_word(r_line, r_vaddr[3:2]);
                end
                w_discard_n = 1'b0;
                w_state_n   = IC_IDLE;
            end
            default: begin
                w_state_n = IC_IDLE;
            end
        endcase
    end

    // State register and all registered outputs, with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state        <= IC_IDLE;
            r_line         <= 128'd0;
            r_tag          <= 36'd0;
            r_line_valid   <= 1'b0;
            r_discard      <= 1'b0;
            r_vaddr        <= 40'd0;
            r_err          <= 1'b0;
            r_resp         <= '0;
            r_l2_req_valid <= 1'b0;
            r_l2_req_addr  <= 40'd0;
        end else begin
            r_state        <= w_state_n;
            r_line         <= w_line_n;
            r_tag          <= w_tag_n;
            r_line_valid   <= w_line_valid_n;
            r_discard      <= w_discard_n;
            r_vaddr        <= w_vaddr_n;
            r_err          <= w_err_n;
            r_resp         <= w_resp_n;
            r_l2_req_valid <= w_l2_req_valid_n;
            r_l2_req_addr  <= w_l2_req_addr_n;
        end
    end

endmodule

// File: tb/tb_icache_line_responder.sv
// Directed bench for icache_line_responder: refill latency, hits, faults, retry, invalidate, reset.
module tb_icache_line_responder;
    import drac_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    req_cpu_icache_t  req;
    resp_icache_cpu_t resp;
    logic             retry;
    logic             l2_req_valid;
    logic [39:0]      l2_req_addr;
    logic             l2_req_ready;
    logic             l2_resp_valid;
    logic [127:0]     l2_resp_data;
    logic             l2_resp_error;

    int checks   = 0;
    int failures = 0;

    localparam logic [127:0] LINE_A = 128'h44444444_33333333_22222222_11111111;
    localparam logic [127:0] LINE_B = 128'hdddddddd_cccccccc_bbbbbbbb_aaaaaaaa;

    icache_line_responder dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .req_cpu_icache_i  (req),
        .resp_icache_cpu_o (resp),
        .retry_fetch_o     (retry),
        .l2_req_valid_o    (l2_req_valid),
        .l2_req_addr_o     (l2_req_addr),
        .l2_req_ready_i    (l2_req_ready),
        .l2_resp_valid_i   (l2_resp_valid),
        .l2_resp_data_i    (l2_resp_data),
        .l2_resp_error_i   (l2_resp_error)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [39:0] addr);
        req       = '0;
        req.valid = 1'b1;
        req.vaddr = addr;
    endtask

    function automatic resp_icache_cpu_t mk(input logic v, input logic [31:0] d, input logic af, input logic pf);
        resp_icache_cpu_t r;
        r.valid              = v;
        r.data               = d;
        r.instr_access_fault = af;
        r.instr_page_fault   = pf;
        return r;
    endfunction

    // Called one cycle after a missing request; returns in the RESPOND cycle.
    task automatic serve_line(input logic [127:0] data, input logic err);
        int n;
        n = 0;
        while (!l2_req_valid && n < 10) begin
            tick();
            n++;
        end
        if (!l2_req_valid) begin
            failures++;
            $display("FAIL serve_timeout l2_req_valid got=%0b want=1", l2_req_valid);
        end
        l2_req_ready = 1'b1;
        tick();
        l2_req_ready  = 1'b0;
        l2_resp_valid = 1'b1;
        l2_resp_data  = data;
        l2_resp_error = err;
        tick();
        l2_resp_valid = 1'b0;
        l2_resp_error = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; l2_req_ready = 1'b0; l2_resp_valid = 1'b0;
        l2_resp_data = 128'd0; l2_resp_error = 1'b0;
        @(negedge clk);
        tick();
        tick();
        checks++;
        if (resp !== mk(1'b0, 32'd0, 1'b0, 1'b0)) begin
            failures++; $display("FAIL reset_resp got=%h want=0", resp);
        end
        checks++;
        if ({retry, l2_req_valid, l2_req_addr} !== 42'd0) begin
            failures++; $display("FAIL reset_ctl got=%b/%b/%h want=0", retry, l2_req_valid, l2_req_addr);
        end
        checks++;
        if (dut.r_state !== IC_IDLE || dut.r_line_valid !== 1'b0 || dut.r_discard !== 1'b0) begin
            failures++; $display("FAIL reset_state got=%0d/%b/%b want=IDLE/0/0", dut.r_state, dut.r_line_valid, dut.r_discard);
        end
        rst = 1'b0;
    endtask

    task automatic test_refill_hit();
        send(40'h0080000008);
        tick();                                   // N+1
        req = '0;
        checks++;
        if (l2_req_valid !== 1'b1 || l2_req_addr !== 40'h0080000000) begin
            failures++; $display("FAIL miss_l2req got=%b/%h want=1/0080000000", l2_req_valid, l2_req_addr);
        end
        l2_req_ready = 1'b1;
        tick();                                   // N+2
        l2_req_ready = 1'b0;
        l2_resp_valid = 1'b1; l2_resp_data = LINE_A;
        tick();                                   // N+3
        l2_resp_valid = 1'b0;
        checks++;
        if (resp.valid !== 1'b0 || l2_req_valid !== 1'b0) begin
            failures++; $display("FAIL miss_early got=%b/%b want=0/0", resp.valid, l2_req_valid);
        end
        tick();                                   // N+4
        checks++;
        if (resp !== mk(1'b1, 32'h33333333, 1'b0, 1'b0)) begin
            failures++; $display("FAIL miss_resp got=%h want=%h", resp, mk(1'b1, 32'h33333333, 1'b0, 1'b0));
        end
        send(40'h008000000C);
        tick();
        req = '0;
        checks++;
        if (resp !== mk(1'b1, 32'h44444444, 1'b0, 1'b0)) begin
            failures++; $display("FAIL hit_after_refill got=%h want=%h", resp, mk(1'b1, 32'h44444444, 1'b0, 1'b0));
        end
        tick();
        checks++;
        if (resp.valid !== 1'b0) begin
            failures++; $display("FAIL resp_pulse got=%b want=0", resp.valid);
        end
    endtask

    task automatic test_back_to_back();
        send(40'h0080000000);
        tick();
        send(40'h0080000007);                     // low two bits ignored -> word 1
        checks++;
        if (resp !== mk(1'b1, 32'h11111111, 1'b0, 1'b0)) begin
            failures++; $display("FAIL b2b_0 got=%h want=%h", resp, mk(1'b1, 32'h11111111, 1'b0, 1'b0));
        end
        tick();
        req = '0;
        checks++;
        if (resp !== mk(1'b1, 32'h22222222, 1'b0, 1'b0)) begin
            failures++; $display("FAIL b2b_1 got=%h want=%h", resp, mk(1'b1, 32'h22222222, 1'b0, 1'b0));
        end
        tick();
    endtask

    task automatic test_invalidate_same_cycle();
        send(40'h0080000000);
        req.invalidate_icache = 1'b1;
        tick();
        req = '0;
        checks++;
        if (resp.valid !== 1'b0 || l2_req_valid !== 1'b1) begin
            failures++; $display("FAIL inv_same_cycle got=%b/%b want=0/1", resp.valid, l2_req_valid);
        end
        serve_line(LINE_A, 1'b0);
        tick();
        checks++;
        if (resp !== mk(1'b1, 32'h11111111, 1'b0, 1'b0)) begin
            failures++; $display("FAIL inv_refill got=%h want=%h", resp, mk(1'b1, 32'h11111111, 1'b0, 1'b0));
        end
    endtask

    task automatic test_faults();
        logic [39:0] addrs [4];
        logic        pf    [4];
        addrs[0] = 40'h4000000000; pf[0] = 1'b1;
        addrs[1] = 40'h0000001000; pf[1] = 1'b0;
        addrs[2] = 40'h0090000000; pf[2] = 1'b0;  // first byte past the region
        addrs[3] = 40'h007FFFFFFC; pf[3] = 1'b0;  // last word below the region
        for (int i = 0; i < 4; i++) begin
            send(addrs[i]);
            tick();
            req = '0;
            checks++;
            if (resp !== mk(1'b1, 32'd0, ~pf[i], pf[i]) || l2_req_valid !== 1'b0) begin
                failures++;
                $display("FAIL fault_%0d got=%h l2=%b want=%h l2=0", i, resp, l2_req_valid, mk(1'b1, 32'd0, ~pf[i], pf[i]));
            end
        end
        tick();
    endtask

    task automatic test_refill_error();
        send(40'h0080000104);
        tick();
        req = '0;
        serve_line(LINE_B, 1'b1);
        tick();
        checks++;
        if (resp !== mk(1'b1, 32'd0, 1'b1, 1'b0)) begin
            failures++; $display("FAIL err_resp got=%h want=%h", resp, mk(1'b1, 32'd0, 1'b1, 1'b0));
        end
        send(40'h0080000104);
        tick();
        req = '0;
        checks++;
        if (resp.valid !== 1'b0 || l2_req_valid !== 1'b1 || l2_req_addr !== 40'h0080000100) begin
            failures++; $display("FAIL err_remiss got=%b/%b/%h want=0/1/0080000100", resp.valid, l2_req_valid, l2_req_addr);
        end
        serve_line(LINE_B, 1'b0);
        tick();
        checks++;
        if (resp !== mk(1'b1, 32'hbbbbbbbb, 1'b0, 1'b0)) begin
            failures++; $display("FAIL err_retry_resp got=%h want=%h", resp, mk(1'b1, 32'hbbbbbbbb, 1'b0, 1'b0));
        end
    endtask

    task automatic test_retry();
        send(40'h0080000208);
        tick();
        req = '0;
        l2_req_ready = 1'b1;
        tick();                                   // now in REFILL_WAIT
        l2_req_ready = 1'b0;
        send(40'h0080000100);
        #1;
        checks++;
        if (retry !== 1'b1) begin
            failures++; $display("FAIL retry_wait got=%b want=1", retry);
        end
        tick();
        req = '0;
        l2_resp_valid = 1'b1; l2_resp_data = LINE_A;
        #1;
        checks++;
        if (retry !== 1'b0 || resp.valid !== 1'b0) begin
            failures++; $display("FAIL retry_dropped got=%b/%b want=0/0", retry, resp.valid);
        end
        tick();
        l2_resp_valid = 1'b0;
        tick();
        checks++;
        if (resp !== mk(1'b1, 32'h33333333, 1'b0, 1'b0)) begin
            failures++; $display("FAIL retry_resp got=%h want=%h", resp, mk(1'b1, 32'h33333333, 1'b0, 1'b0));
        end
    endtask

    task automatic test_invalidate_wait();
        send(40'h0080000304);
        tick();
        req = '0;
        l2_req_ready = 1'b1;
        tick();
        l2_req_ready = 1'b0;
        req.invalidate_buffer = 1'b1;
        tick();
        req = '0;
        l2_resp_valid = 1'b1; l2_resp_data = LINE_B;
        tick();
        l2_resp_valid = 1'b0;
        tick();
        checks++;
        if (resp !== mk(1'b1, 32'hbbbbbbbb, 1'b0, 1'b0)) begin
            failures++; $display("FAIL discard_resp got=%h want=%h", resp, mk(1'b1, 32'hbbbbbbbb, 1'b0, 1'b0));
        end
        send(40'h0080000300);
        tick();
        req = '0;
        checks++;
        if (resp.valid !== 1'b0 || l2_req_valid !== 1'b1) begin
            failures++; $display("FAIL discard_remiss got=%b/%b want=0/1", resp.valid, l2_req_valid);
        end
        serve_line(LINE_B, 1'b0);
        tick();
        checks++;
        if (resp !== mk(1'b1, 32'haaaaaaaa, 1'b0, 1'b0)) begin
            failures++; $display("FAIL discard_refill got=%h want=%h", resp, mk(1'b1, 32'haaaaaaaa, 1'b0, 1'b0));
        end
    endtask

    task automatic test_reset_mid_refill();
        send(40'h0080000500);
        tick();
        req = '0;
        l2_req_ready = 1'b1;
        tick();
        l2_req_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        l2_resp_valid = 1'b1; l2_resp_data = LINE_A;
        tick();
        l2_resp_valid = 1'b0;
        tick();
        checks++;
        if (resp.valid !== 1'b0 || l2_req_valid !== 1'b0 || dut.r_state !== IC_IDLE) begin
            failures++; $display("FAIL rst_mid got=%b/%b/%0d want=0/0/IDLE", resp.valid, l2_req_valid, dut.r_state);
        end
        send(40'h0080000500);
        tick();
        req = '0;
        checks++;
        if (resp.valid !== 1'b0 || l2_req_valid !== 1'b1) begin
            failures++; $display("FAIL rst_mid_miss got=%b/%b want=0/1", resp.valid, l2_req_valid);
        end
        serve_line(LINE_A, 1'b0);
        tick();
        checks++;
        if (resp !== mk(1'b1, 32'h11111111, 1'b0, 1'b0)) begin
            failures++; $display("FAIL rst_mid_refill got=%h want=%h", resp, mk(1'b1, 32'h11111111, 1'b0, 1'b0));
        end
    endtask

    initial begin
        test_reset();
        test_refill_hit();
        test_back_to_back();
        test_invalidate_same_cycle();
        test_faults();
        test_refill_error();
        test_retry();
        test_invalidate_wait();
        test_reset_mid_refill();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/icache_line_responder.md
# icache_line_responder

Cache-side responder for the fetch interface. It accepts `req_cpu_icache_t` requests from `if_stage` and returns one `resp_icache_cpu_t` per accepted request. It keeps a single 128-bit line buffer and refills it from L2 over a valid/ready request and valid-only response channel. It sits between `if_stage` and the L2 port, and also serves as the icache model in datapath simulations.

## Interface

Parameters:
- `MEM_BASE`, default `40'h0080000000`: first cacheable/accessible byte.
- `MEM_SIZE`, default `40'h0010000000`: accessible region size in bytes.
- `VA_BITS`, default 39: canonical virtual address width.

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset, synchronous, active-high.
- `req_cpu_icache_i`  in  `req_cpu_icache_t`  fields `valid`, `vaddr` (40), `invalidate_icache`, `invalidate_buffer`.
- `resp_icache_cpu_o`  out  `resp_icache_cpu_t`  fields `valid`, `data` (32), `instr_access_fault`, `instr_page_fault`.
- `retry_fetch_o`  out  1  the request this cycle was dropped and must be replayed.
- `l2_req_valid_o`  out  1  refill request.
- `l2_req_addr_o`  out  40  line-aligned refill address (`[3:0]`=0).
- `l2_req_ready_i`  in  1  L2 accepts the request.
- `l2_resp_valid_i`  in  1  refill data valid.
- `l2_resp_data_i`  in  128  line data; word k is `[32k+31:32k]`.
- `l2_resp_error_i`  in  1  bus error on the refill.

## Operation

- FSM states and transitions:
  - IDLE: a valid request goes to REFILL_REQ on a miss, or stays in IDLE on a hit or fault.
  - REFILL_REQ: moves to REFILL_WAIT when `l2_req_ready_i` is high.
  - REFILL_WAIT: moves to RESPOND when `l2_resp_valid_i` is high.
  - RESPOND: returns to IDLE.
- Requests are accepted only in IDLE. A valid request in any other state asserts `retry_fetch_o` in that same cycle, combinationally, and the request is dropped.
- Fault checks run on the accepted `vaddr`. Page fault has priority over access fault.
  - Page fault: `vaddr[39:VA_BITS-1]` is not all-equal. Response sets `instr_page_fault`=1 and `data`=0.
  - Access fault: `vaddr` is outside `[MEM_BASE, MEM_BASE+MEM_SIZE)`. The comparison uses 41-bit arithmetic so the upper bound cannot wrap. Response sets `instr_access_fault`=1 and `data`=0.
  - A faulting request never starts a refill.
- Hit: line valid and tag equals `vaddr[39:4]`. Response `data` is the word at `vaddr[3:2]`. `vaddr[1:0]` is ignored, because misalignment is the fetch stage's job.
- Refill:
  - Captures `vaddr`.
  - Drives `l2_req_addr_o` = `{vaddr[39:4],4'b0}` and holds it stable while `l2_req_valid_o` is high.
  - On `l2_resp_valid_i` it installs the line and tag.
  - RESPOND returns the captured word from the registered line.
  - If `l2_resp_error_i` is set, the line is not installed and the response carries `instr_access_fault`=1, `data`=0.
- Invalidate: `invalidate_icache` or `invalidate_buffer` clears line-valid at the clock edge.
  - With a request in the same cycle, the invalidate applies first, so the request misses.
  - An invalidate seen during REFILL_REQ or REFILL_WAIT sets a discard flag. The pending response is still delivered, but the line stays invalid.
- Reset mid-refill: the FSM goes to IDLE and any late `l2_resp_valid_i` is ignored. L2 must not be left holding an accepted request across reset; this is a system-level requirement.

## Timing

- Reset values:
  - All `resp_icache_cpu_o` fields are 0.
  - `retry_fetch_o`, `l2_req_valid_o`, and `l2_req_addr_o` are 0.
  - Line-valid and the discard flag are 0; state is IDLE.
- Response outputs are registered, and `valid` is a single-cycle pulse.
- Hit or fault: request in cycle N, response in N+1, and a new request is accepted in N+1.
- Miss:
  - Request in N; `l2_req_valid_o` is high from N+1 until the ready handshake.
  - `l2_resp_valid_i` is legal one cycle after the handshake at the earliest.
  - Response appears one cycle after the RESPOND entry edge.
  - Minimum latency is N+4 with ready at N+1 and L2 data at N+2.
- Back-to-back hits give one response per cycle.

## Structure

- `drac_pkg` additions:
  - `icache_line_t` (128 bits), `ic_tag_t` (36 bits).
  - `ICACHE_LINE_BYTES` = 16.
  - The `icache_resp_state_t` enum.
- Sub-module `icache_fetch_fault_chk` (combinational): canonical check and range check, producing page and access flags. Everything else lives in one module.

## Test plan

- Reset with `rst_i`=1 for 2 cycles: all outputs are 0 and the state is IDLE.
- Request `vaddr`=`0x0080000008` with the line empty:
  - `l2_req_addr_o`=`0x0080000000`.
  - L2 returns `0x44444444_33333333_22222222_11111111` with ready at N+1 and data at N+2.
  - Response `data`=`0x33333333` at N+4.
  - The next request to `0x008000000C` hits, giving `0x44444444` one cycle later.
- Request `vaddr`=`0x4000000000`: `instr_page_fault`=1 next cycle and no L2 request.
- Request `vaddr`=`0x0000001000`: `instr_access_fault`=1.
- Refill with `l2_resp_error_i`=1: `instr_access_fault`=1, then a re-request to the same line misses again.
- Request during REFILL_WAIT: `retry_fetch_o`=1 in that cycle. Separately, `invalidate_buffer` during REFILL_WAIT: the response is delivered and the next same-line request misses.
